// File: rtl/gshare_pht_ctrl.sv
// Gshare PHT front-end/update controller: PC^GHR read index, counter-MSB
// prediction, in-order in-flight queue, saturating-counter write-back and
// GHR repair on misprediction.
module gshare_pht_ctrl #(
    parameter int INDEX_WIDTH   = 8,
    parameter int COUNTER_WIDTH = 2,
    parameter int QUEUE_DEPTH   = 4,
    parameter int PC_LSB        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pred_valid,
    input  logic [31:0]                      pred_pc,
    output logic                             pred_ready,
    output logic                             pred_taken,
    output logic [INDEX_WIDTH-1:0]           RD_index,
    input  logic [COUNTER_WIDTH-1:0]         RD_count,
    input  logic                             res_valid,
    input  logic                             res_taken,
    output logic                             flush,
    output logic                             WR_en,
    output logic [INDEX_WIDTH-1:0]           WR_index,
    output logic [COUNTER_WIDTH-1:0]         WR_count,
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    // Queue storage
    logic [INDEX_WIDTH-1:0]   q_index_q [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0]   q_index_d [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] q_count_q [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] q_count_d [QUEUE_DEPTH];
    logic                     q_taken_q [QUEUE_DEPTH];
    logic                     q_taken_d [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0]   q_ghr_q   [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0]   q_ghr_d   [QUEUE_DEPTH];

    // Control state
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic [INDEX_WIDTH-1:0]   ghr_q, ghr_d;
    logic                     wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0]   wr_index_q, wr_index_d;
    logic [COUNTER_WIDTH-1:0] wr_count_q, wr_count_d;

    logic                     empty;
    logic                     full;
    logic                     resolve;
    logic                     push;
    logic [COUNTER_WIDTH-1:0] head_count;
    logic [COUNTER_WIDTH-1:0] upd_count;

    // Read-side hash, prediction, accept and resolve decisions
    always_comb begin
        empty      = (occ_q == '0);
        full       = (occ_q == OCC_W'(QUEUE_DEPTH));
        RD_index   = pred_pc[PC_LSB +: INDEX_WIDTH] ^ ghr_q;
        pred_taken = RD_count[COUNTER_WIDTH-1];
        resolve    = res_valid && !empty;
        flush      = resolve && (res_taken != q_taken_q[head_q]);
        pred_ready = !full && !flush;
        push       = pred_valid && pred_ready;
        head_count = q_count_q[head_q];
        upd_count  = head_count;
        if (res_taken) begin
            if (head_count != CNT_MAX) upd_count = head_count + COUNTER_WIDTH'(1);
        end else begin
            if (head_count != '0) upd_count = head_count - COUNTER_WIDTH'(1);
        end
    end

    // Next-state for queue, GHR and PHT write port
    always_comb begin
        q_index_d  = q_index_q;
        q_count_d  = q_count_q;
        q_taken_d  = q_taken_q;
        q_ghr_d    = q_ghr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        ghr_d      = ghr_q;
        wr_en_d    = resolve;
        wr_index_d = wr_index_q;
        wr_count_d = wr_count_q;

        if (resolve) begin
            wr_index_d = q_index_q[head_q];
            wr_count_d = upd_count;
        end

        if (flush) begin
            // Misprediction: drop all younger entries, rebuild GHR from the
            // snapshot taken when the head was predicted.
            head_d = head_q + PTR_W'(1);
            tail_d = head_q + PTR_W'(1);
            occ_d  = '0;
            ghr_d  = {q_ghr_q[head_q][INDEX_WIDTH-2:0], res_taken};
        end else begin
            if (push) begin
                q_index_d[tail_q] = RD_index;
                q_count_d[tail_q] = RD_count;
                q_taken_d[tail_q] = pred_taken;
                q_ghr_d[tail_q]   = ghr_q;
                tail_d            = tail_q + PTR_W'(1);
                ghr_d             = {ghr_q[INDEX_WIDTH-2:0], pred_taken};
            end
            if (resolve) head_d = head_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(push) - OCC_W'(resolve);
        end
    end

    // Queue payload registers (contents are don't-care while invalid)
    always_ff @(posedge clk) begin
        q_index_q <= q_index_d;
        q_count_q <= q_count_d;
        q_taken_q <= q_taken_d;
        q_ghr_q   <= q_ghr_d;
    end

    // Control and write-port registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            ghr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_count_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            ghr_q      <= ghr_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign WR_en     = wr_en_q;
    assign WR_index  = wr_index_q;
    assign WR_count  = wr_count_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Directed bench for gshare_pht_ctrl with hand-computed expectations.
// GHR is observed through RD_index while pred_pc=0.
module tb_gshare_pht_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        pred_taken;
    logic [7:0]  RD_index;
    logic [1:0]  RD_count;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        WR_en;
    logic [7:0]  WR_index;
    logic [1:0]  WR_count;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    gshare_pht_ctrl #(
        .INDEX_WIDTH(8),
        .COUNTER_WIDTH(2),
        .QUEUE_DEPTH(4),
        .PC_LSB(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pred_valid(pred_valid),
        .pred_pc(pred_pc),
        .pred_ready(pred_ready),
        .pred_taken(pred_taken),
        .RD_index(RD_index),
        .RD_count(RD_count),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .flush(flush),
        .WR_en(WR_en),
        .WR_index(WR_index),
        .WR_count(WR_count),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Timeout guard
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0; pred_pc = 32'h0; RD_count = 2'd0;
        res_valid = 1'b0; res_taken = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input logic [1:0] cnt);
        pred_valid = 1'b1; pred_pc = pc; RD_count = cnt;
        res_valid = 1'b0; res_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        chk("rst_occ", occupancy, 0);
        chk("rst_wr_en", WR_en, 0);
        chk("rst_wr_index", WR_index, 0);
        chk("rst_wr_count", WR_count, 0);
        rst = 1'b0;
        #1 chk("rst_ghr", RD_index, 8'h00);

        // First prediction: pc 0x40 -> index 0x10, weakly taken
        predict(32'h0000_0040, 2'd2);
        #1;
        chk("p1_index", RD_index, 8'h10);
        chk("p1_taken", pred_taken, 1);
        chk("p1_ready", pred_ready, 1);
        tick();
        idle();
        #1;
        chk("p1_occ", occupancy, 1);
        chk("p1_ghr", RD_index, 8'h01);

        // Correct taken resolve -> counter 2 -> 3
        res_valid = 1'b1; res_taken = 1'b1;
        #1 chk("r1_flush", flush, 0);
        tick();
        idle();
        chk("r1_wr_en", WR_en, 1);
        chk("r1_wr_index", WR_index, 8'h10);
        chk("r1_wr_count", WR_count, 2'd3);
        chk("r1_occ", occupancy, 0);

        // Saturation at max: GHR=0x01 -> index 0x11
        predict(32'h0000_0040, 2'd3);
        #1 chk("p2_index", RD_index, 8'h11);
        tick();
        chk("r1_wr_pulse", WR_en, 0);
        idle(); res_valid = 1'b1; res_taken = 1'b1;
        #1 chk("r2_flush", flush, 0);
        tick();
        idle();
        chk("r2_wr_index", WR_index, 8'h11);
        chk("r2_wr_count", WR_count, 2'd3);

        // Saturation at zero: GHR=0x03 -> index 0x13
        predict(32'h0000_0040, 2'd0);
        #1;
        chk("p3_index", RD_index, 8'h13);
        chk("p3_taken", pred_taken, 0);
        tick();
        idle(); res_valid = 1'b1; res_taken = 1'b0;
        #1 chk("r3_flush", flush, 0);
        tick();
        idle();
        chk("r3_wr_en", WR_en, 1);
        chk("r3_wr_index", WR_index, 8'h13);
        chk("r3_wr_count", WR_count, 2'd0);
        #1 chk("r3_ghr", RD_index, 8'h06);

        // Fill the queue: four not-taken predictions from GHR 0x06
        for (int i = 0; i < 4; i++) begin
            predict(32'h0, 2'd0);
            tick();
        end
        #1;
        chk("full_occ", occupancy, 4);
        chk("full_ready", pred_ready, 0);
        chk("full_ghr", RD_index, 8'h60);
        // Fifth request with a simultaneous correct resolve: still refused
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk("full_res_ready", pred_ready, 0);
        chk("full_res_flush", flush, 0);
        tick();
        chk("full_res_occ", occupancy, 3);
        chk("full_res_wr_index", WR_index, 8'h06);
        chk("full_res_wr_count", WR_count, 2'd0);
        idle();
        #1 chk("full_res_ghr", RD_index, 8'h60);

        // Drain with back-to-back resolves
        res_valid = 1'b1; res_taken = 1'b0;
        tick();
        chk("drain1_wr_en", WR_en, 1);
        chk("drain1_wr_index", WR_index, 8'h0C);
        tick();
        chk("drain2_wr_en", WR_en, 1);
        chk("drain2_wr_index", WR_index, 8'h18);
        tick();
        chk("drain3_wr_en", WR_en, 1);
        chk("drain3_wr_index", WR_index, 8'h30);
        chk("drain_occ", occupancy, 0);

        // Accept plus correct resolve in one cycle keeps occupancy
        predict(32'h0, 2'd0);
        tick();
        chk("sim_pre_occ", occupancy, 1);
        predict(32'h0, 2'd0);
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk("sim_index", RD_index, 8'hC0);
        chk("sim_ready", pred_ready, 1);
        tick();
        chk("sim_occ", occupancy, 1);
        chk("sim_wr_index", WR_index, 8'h60);
        idle();
        #1 chk("sim_ghr", RD_index, 8'h80);

        // Restart from GHR=0 for the mispredict scenario
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            predict(32'h0, 2'd2);
            tick();
        end
        idle();
        #1;
        chk("mp_pre_ghr", RD_index, 8'h07);
        chk("mp_pre_occ", occupancy, 3);
        predict(32'h0, 2'd2);
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk("mp_flush", flush, 1);
        chk("mp_ready", pred_ready, 0);
        tick();
        chk("mp_occ", occupancy, 0);
        chk("mp_wr_en", WR_en, 1);
        chk("mp_wr_index", WR_index, 8'h00);
        chk("mp_wr_count", WR_count, 2'd1);
        idle();
        #1 chk("mp_ghr", RD_index, 8'h00);

        // Resolve against an empty queue is ignored
        res_valid = 1'b1; res_taken = 1'b1;
        #1 chk("empty_flush", flush, 0);
        tick();
        chk("empty_wr_en", WR_en, 0);
        chk("empty_occ", occupancy, 0);

        // Post-flush queue still works: GHR 0x00 -> index 0x00, then 0x01
        predict(32'h0, 2'd3);
        tick();
        predict(32'h0, 2'd3);
        #1 chk("pf_index", RD_index, 8'h01);
        tick();
        chk("pf_occ", occupancy, 2);

        // Reset mid-operation with a resolve pending
        idle();
        rst = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mrst_occ", occupancy, 0);
        chk("mrst_wr_en", WR_en, 0);
        #1 chk("mrst_ghr", RD_index, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
